lfsr_range_gen: RTL

//  Parametrised XNOR Fibonacci LFSR random source with seed load and multi-step advance.
//  On request, a sequential shift-subtract divider reduces a snapshot of the state modulo
//  a run-time range and returns it with a valid pulse.

---
 rtl/lfsr_range_gen.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/lfsr_range_gen.sv
// XNOR Fibonacci LFSR random source with seed load, multi-step advance and a sequential
// shift-subtract reducer (state mod range). Define LFSR_STATS_EN to add the draw_count port.
module lfsr_range_gen #(
  parameter int unsigned      WIDTH = 16,
  parameter logic [WIDTH-1:0] TAPS  = 16'hB400,
  parameter int unsigned      OUT_W = 7,
  parameter int unsigned      STEPS = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             seed_load,
  input  logic [WIDTH-1:0] seed,
  input  logic             req,
  input  logic [OUT_W-1:0] range,
  output logic             busy,
  output logic             valid,
  output logic [OUT_W-1:0] number,
`ifdef LFSR_STATS_EN
  output logic [31:0]      draw_count,
`endif
  output logic [WIDTH-1:0] state_out
);

  localparam int unsigned CntW = $clog2(WIDTH);

  typedef enum logic [1:0] {StIdle, StDiv, StDone} state_e;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  lfsr_q, lfsr_d, lfsr_step;
  logic [WIDTH-1:0]  snap_q, snap_d;
  logic [OUT_W-1:0]  mod_q, mod_d;
  logic [OUT_W:0]    rem_q, rem_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [OUT_W-1:0]  number_q, number_d;
  logic              valid_q, valid_d;
  logic [OUT_W+1:0]  trial, mod_ext;

  // LFSR: seed_load beats enable; the all-ones lockup seed is replaced by zero.
  always_comb begin
    lfsr_step = lfsr_q;
    for (int unsigned i = 0; i < STEPS; i++) begin
      lfsr_step = {lfsr_step[WIDTH-2:0], ~^(lfsr_step & TAPS)};
    end
    lfsr_d = lfsr_q;
    if (seed_load) begin
      lfsr_d = (&seed) ? '0 : seed;
    end else if (enable) begin
      lfsr_d = lfsr_step;
    end
  end

  assign trial   = {rem_q, snap_q[cnt_q]};
  assign mod_ext = {2'b00, mod_q};

  always_comb begin
    state_d  = state_q;
    snap_d   = snap_q;
    mod_d    = mod_q;
    rem_d    = rem_q;
    cnt_d    = cnt_q;
    number_d = number_q;
    valid_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (req) begin
          snap_d = lfsr_q;
          mod_d  = range;
          if (range == '0) begin
            state_d = StDone;
          end else begin
            rem_d   = '0;
            cnt_d   = CntW'(WIDTH - 1);
            state_d = StDiv;
          end
        end
      end
      StDiv: begin
        if (trial >= mod_ext) begin
          rem_d = OUT_W'(trial - mod_ext);
        end else begin
          rem_d = trial[OUT_W:0];
        end
        if (cnt_q == '0) begin
          state_d = StDone;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StDone: begin
        number_d = (mod_q == '0) ? snap_q[OUT_W-1:0] : rem_q[OUT_W-1:0];
        valid_d  = 1'b1;
        state_d  = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      lfsr_q   <= '0;
      snap_q   <= '0;
      mod_q    <= '0;
      rem_q    <= '0;
      cnt_q    <= '0;
      number_q <= '0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      lfsr_q   <= lfsr_d;
      snap_q   <= snap_d;
      mod_q    <= mod_d;
      rem_q    <= rem_d;
      cnt_q    <= cnt_d;
      number_q <= number_d;
      valid_q  <= valid_d;
    end
  end

`ifdef LFSR_STATS_EN
  logic [31:0] draw_count_q;

  // Counts alongside valid_q, wrapping naturally at 2^32.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      draw_count_q <= '0;
    end else if (valid_d) begin
      draw_count_q <= draw_count_q + 32'd1;
    end
  end

  assign draw_count = draw_count_q;
`endif

  assign busy      = (state_q != StIdle);
  assign valid     = valid_q;
  assign number    = number_q;
  assign state_out = lfsr_q;

endmodule
